// File: rtl/recip_pkg.sv
// Shared types, widths and coefficient generator for the reciprocal interpolator.
// Table entries describe f(u) = (128-u)/(128+u) scaled by 2^26-2, one segment per idx:
//   base = round(S*(128-i)/(128+i)),  sd = round(2^32/(i+128.5)^3),
//   fd   = floor((base[i]-base[i+1])/4) + sd.
package recip_pkg;

  localparam int unsigned IDX_W  = 7;
  localparam int unsigned DX_W   = 9;
  localparam int unsigned BASE_W = 27;
  localparam int unsigned FD_W   = 18;
  localparam int unsigned SD_W   = 11;
  localparam int unsigned T1_SH  = 7;
  localparam int unsigned T2_SH  = 15;

  localparam int unsigned X_W    = IDX_W + DX_W;
  localparam int unsigned ACC_W  = 28;
  localparam int unsigned DXSQ_W = 18;
  localparam int unsigned MA_W   = 18;
  localparam int unsigned MB_W   = 11;
  localparam int unsigned PROD_W = MA_W + MB_W;
  localparam int unsigned T1_W   = 20;
  localparam int unsigned T2_W   = 14;
  localparam int unsigned TAB_N  = 128;

  localparam longint unsigned BASE_SCALE = 64'd67108862;

  typedef enum logic [2:0] {
    IDLE,
    LKP,
    M1,
    M2,
    M3,
    OUT
  } recip_state_t;

  typedef struct packed {
    logic [BASE_W-1:0] base;
    logic [FD_W-1:0]   fd;
    logic [SD_W-1:0]   sd;
  } recip_coef_t;

  // Rounded base value at segment start i (i = 128 gives 0, used for the last chord).
  function automatic longint unsigned base_at(input int unsigned i);
    longint unsigned n;
    longint unsigned d;
    n = BASE_SCALE * 64'(TAB_N - i);
    d = 64'(TAB_N + i);
    return (64'd2 * n + d) / (64'd2 * d);
  endfunction

  // Full coefficient triple for segment i; evaluated only with constant arguments.
  function automatic recip_coef_t coef_at(input int unsigned i);
    longint unsigned b0;
    longint unsigned b1;
    longint unsigned d3;
    longint unsigned sdv;
    longint unsigned fdv;
    recip_coef_t     c;
    b0  = base_at(i);
    b1  = base_at(i + 1);
    d3  = 64'd257 + 64'd2 * 64'(i);
    d3  = d3 * d3 * d3;
    sdv = ((64'd1 << 36) + d3) / (64'd2 * d3);
    fdv = (b0 - b1) / 64'd4 + sdv;
    c.base = BASE_W'(b0);
    c.fd   = FD_W'(fdv);
    c.sd   = SD_W'(sdv);
    return c;
  endfunction

endpackage

// File: rtl/recip_interp_eval_tab.sv
// 128-entry reciprocal coefficient ROM.
// Ports: idx (segment index) in, coef (base/fd/sd) out, purely combinational.
module recip_interp_eval_tab
  import recip_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output recip_coef_t      coef
);

  recip_coef_t rom [TAB_N];

  // Constant entries folded at elaboration.
  for (genvar g = 0; g < TAB_N; g++) begin : g_rom
    assign rom[g] = coef_at(32'(g));
  end

  assign coef = rom[idx];

endmodule

// File: rtl/recip_interp_eval.sv
// Sequential quadratic interpolator: y = base - (fd*dx)>>7 + (sd*dx^2)>>15.
// One shared 18x11 multiplier is time-multiplexed over states M1..M3.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/x operand side;
//        out_valid/out_ready/y result side; busy high outside IDLE.
module recip_interp_eval
  import recip_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [X_W-1:0]    x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BASE_W-1:0] y,
  output logic              busy
);

  recip_state_t state_q, state_d;

  logic [IDX_W-1:0]         idx_q;
  logic [DX_W-1:0]          dx_q;
  recip_coef_t              tab_coef;
  recip_coef_t              coef_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [DXSQ_W-1:0]        dxsq_q;

  logic [MA_W-1:0]          mul_a;
  logic [MB_W-1:0]          mul_b;
  logic [PROD_W-1:0]        prod;
  logic [T1_W-1:0]          t1;
  logic [T2_W-1:0]          t2;
  logic signed [ACC_W-1:0]  acc_m1;
  logic signed [ACC_W-1:0]  acc_m3;

  recip_interp_eval_tab u_tab (
    .idx  (idx_q),
    .coef (tab_coef)
  );

  // Multiplier operand select by state.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      M1: begin
        mul_a = coef_q.fd;
        mul_b = MB_W'(dx_q);
      end
      M2: begin
        mul_a = MA_W'(dx_q);
        mul_b = MB_W'(dx_q);
      end
      M3: begin
        mul_a = dxsq_q;
        mul_b = coef_q.sd;
      end
      default: ;
    endcase
  end

  assign prod   = PROD_W'(mul_a) * PROD_W'(mul_b);
  // fd*dx fits 27 bits, so bits [26:7] are the whole truncated term.
  assign t1     = prod[T1_SH +: T1_W];
  assign t2     = prod[T2_SH +: T2_W];
  assign acc_m1 = $signed(ACC_W'(coef_q.base)) - $signed(ACC_W'(t1));
  assign acc_m3 = acc_q + $signed(ACC_W'(t2));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = LKP;
      LKP:     state_d = M1;
      M1:      state_d = M2;
      M2:      state_d = M3;
      M3:      state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake/status outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == OUT);
      busy      <= (state_d != IDLE);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      dx_q   <= '0;
      coef_q <= '0;
      acc_q  <= '0;
      dxsq_q <= '0;
      y      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            idx_q <= x[X_W-1 -: IDX_W];
            dx_q  <= x[DX_W-1:0];
          end
        end
        LKP: coef_q <= tab_coef;
        M1:  acc_q  <= acc_m1;
        M2:  dxsq_q <= prod[DXSQ_W-1:0];
        M3: begin
          acc_q <= acc_m3;
          // Negative results cannot occur for valid entries; clamp defensively.
          y     <= acc_m3[ACC_W-1] ? '0 : acc_m3[BASE_W-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_recip_interp_eval.sv
// Self-checking bench for recip_interp_eval: directed anchors, backpressure,
// mid-operation reset and a randomized sweep against a real-arithmetic model.
module tb_recip_interp_eval;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic        out_valid;
  logic        out_ready;
  logic [26:0] y;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  recip_interp_eval dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference table from the curve definition, in floating point.
  function automatic longint ref_base(input int i);
    real v;
    v = (67108864.0 - 2.0) * real'(128 - i) / real'(128 + i);
    return longint'($floor(v + 0.5));
  endfunction

  function automatic longint ref_sd(input int i);
    real m;
    real v;
    m = 128.0 + real'(i) + 0.5;
    v = 4294967296.0 / (m * m * m);
    return longint'($floor(v + 0.5));
  endfunction

  function automatic longint ref_fd(input int i);
    return (ref_base(i) - ref_base(i + 1)) / 4 + ref_sd(i);
  endfunction

  function automatic longint ref_y(input logic [15:0] xv);
    int     i;
    longint dx;
    longint r;
    i  = int'(xv[15:9]);
    dx = longint'(xv[8:0]);
    r  = ref_base(i) - (ref_fd(i) * dx) / 128 + (ref_sd(i) * dx * dx) / 32768;
    if (r < 0) r = 0;
    return r;
  endfunction

  // One transaction: accept, latency check, optional backpressure, handshake.
  task automatic do_op(input logic [15:0] xv, input int hold, input logic [26:0] exp_y);
    int lat;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    x         = xv;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 5);
    if (!out_valid) return;
    chk("y", y, exp_y);
    chk("busy_out", busy, 1);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      x        = 16'($urandom);
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_y", y, exp_y);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_busy", busy, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [15:0] xv;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x         = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_y", y, 0);
    rst = 1'b0;

    do_op(16'h0000, 0, 27'h3fffffe);
    do_op(16'hFE00, 0, 27'h0040404);
    do_op(16'h0400, 0, 27'h3e07e06);
    do_op(16'h0100, 0, 27'h3f80fe0);
    do_op(16'h0400, 10, 27'h3e07e06);

    // Reset while in M2 discards the operand.
    @(negedge clk);
    in_valid = 1'b1;
    x        = 16'h0100;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("m2_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_y", y, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    repeat (6) @(negedge clk);
    chk("midrst_no_result", out_valid, 0);
    do_op(16'h0000, 0, 27'h3fffffe);

    // Segment-end boundaries.
    do_op(16'h01FF, 0, 27'(ref_y(16'h01FF)));
    do_op(16'hFFFF, 1, 27'(ref_y(16'hFFFF)));

    // Every segment with random dx and random backpressure.
    for (int i = 0; i < 128; i++) begin
      xv = {7'(i), 9'($urandom)};
      do_op(xv, int'($urandom_range(0, 2)), 27'(ref_y(xv)));
    end
    for (int k = 0; k < 30; k++) begin
      xv = 16'($urandom);
      do_op(xv, int'($urandom_range(0, 3)), 27'(ref_y(xv)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/recip_interp_eval.md
# recip_interp_eval

Sequential evaluator for the 128-entry reciprocal coefficient table. Accepts a 16-bit mantissa fraction, looks up the segment's base, first-difference and second-difference coefficients, and computes the 27-bit interpolated result `base - fd*dx + sd*dx²` with a single shared multiplier. It is the consumer side of the table and sits between the operand-unpack stage and the divide/normalise datapath, using valid/ready on both sides.

## Interface
- Parameters: none. All widths are fixed by the table format.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operand valid.
- `in_ready` out 1: block can accept an operand.
- `x` in 16: mantissa fraction. `idx = x[15:9]` (7 bits), `dx = x[8:0]` (9 bits, unsigned).
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `y` out 27: interpolated result.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, LKP, M1, M2, M3, OUT. One transition per clock.
- IDLE:
  - `in_ready = 1`.
  - On `in_valid && in_ready`, register `idx` and `dx`, then go to LKP.
- LKP: register the table outputs `base[26:0]`, `fd[17:0]` and `sd[10:0]` for `idx`.
- M1:
  - Multiplier computes `p = fd*dx` (27-bit product).
  - `t1 = p >> 7` (20 bits).
  - `acc <= base - t1`.
- M2: multiplier computes `q = dx*dx` (18 bits), registered into `dxsq`.
- M3:
  - Multiplier computes `r = sd*dxsq` (29-bit product).
  - `t2 = r >> 15` (14 bits).
  - `acc <= acc + t2`.
  - Shifts truncate; there is no rounding.
- OUT:
  - `out_valid = 1` and `y = acc[26:0]`.
  - On `out_ready`, go to IDLE.
  - `y` and `out_valid` hold stable while `out_ready` is low.
- Arithmetic:
  - `acc` is 28 bits signed internally.
  - For every table entry the result is non-negative and below 2^27. If the result is negative, clamp `y` to 0; this is defensive only.
- `in_ready` is 0 in every state except IDLE, so there is no accept in the same cycle as the OUT handshake.
- A new operand is never accepted while a result is pending.
- Reset:
  - FSM returns to IDLE.
  - `in_ready = 1`, `out_valid = 0`, `busy = 0`, `y = 0`.
  - `acc`, `dxsq` and the coefficient registers are cleared to 0.
  - Reset mid-operation discards the in-flight operand; no result is produced for it.

## Timing
- Accept edge = cycle 0. States: LKP at cycle 1, M1 at 2, M2 at 3, M3 at 4, OUT at 5.
- `out_valid` is high from cycle 5 and holds until `out_ready` is sampled high.
- With `out_ready` tied high, `in_ready` returns in cycle 6. Minimum initiation interval is 6 cycles.
- All outputs are registered or decoded directly from state. There is no combinational path from `in_valid`/`out_ready` to any output except through state.
- Table lookup is combinational off registered `idx`. The multiplier is an 18×11-bit shared combinational unit with operand muxes selected by state. The critical path is multiplier → shift → 28-bit add into `acc`.

## Structure
- Shared package `recip_pkg` holds:
  - State enum `recip_state_t`.
  - Width constants `IDX_W=7`, `DX_W=9`, `BASE_W=27`, `FD_W=18`, `SD_W=11`.
  - Shift constants `T1_SH=7`, `T2_SH=15`.
- Sub-module: the existing coefficient table, instantiated once as `u_tab`. The shared multiplier stays inline.

## Test plan
- `x=16'h0000`, `out_ready=1` → `y=27'h3fffffe`; `out_valid` rises exactly 5 cycles after accept; `in_ready` high again in cycle 6.
- `x=16'hFE00` (idx 7f, dx 0) → `y=27'h0040404`. `x=16'h0400` (idx 02) → `y=27'h3e07e06`.
- `x=16'h0100` (idx 0, dx 0x100) → `t1=0x7ffee`, `t2=0xfd0` → `y=27'h3f80fe0`.
- Backpressure: hold `out_ready=0` for 10 cycles after the result → `y` and `out_valid` stable throughout; `in_ready=0` and `busy=1` throughout; a new `in_valid` is ignored. Release → exactly one handshake, then IDLE.
- Assert `rst` in state M2 → next cycle: IDLE, `out_valid=0`, `y=0`. Next operand `x=0` → `y=27'h3fffffe` with the normal 5-cycle latency.
- Random sweep of all 128 `idx` values × random `dx` against the reference model `base - ((fd*dx)>>7) + ((sd*dx*dx)>>15)` → exact match, one output per accepted input, in order.
